tdc_measure_ctrl: RTL and testbench
===================================

# tdc_measure_ctrl

Measurement sequencer for one TDC channel. It arms the channel and latches the start and stop FF-column snapshots. It counts coarse clock cycles between the start and stop events, then ones-counts both thermometer columns sequentially, CHUNK bits per cycle, so the combinational depth stays bounded. It delivers {coarse, fine start bin, fine stop bin} to the readout through a valid/ready handshake, and sits between the delay-line capture columns and the readout/FIFO logic.

## Interface
- NUM_FF, 64: taps per capture column; must be a multiple of CHUNK.
- CHUNK, 8: column bits ones-counted per decode cycle.
- BITS_DECO, 8: fine-bin output width; must satisfy 2^BITS_DECO > NUM_FF.
- COARSE_BITS, 16: coarse counter width.
- wClk  in  1  single clock; all state changes on its rising edge.
- wRstN  in  1  reset, asynchronous, active-low.
- wArm  in  1  request one measurement; honoured only in IDLE.
- wAbort  in  1  synchronous abort; returns to IDLE from any state.
- wStartHit  in  1  start event captured this cycle (synchronous flag).
- wStopHit  in  1  stop event captured this cycle (synchronous flag).
- wStartCol  in  NUM_FF  start FF column (thermometer code).
- wStopCol  in  NUM_FF  stop FF column (thermometer code).
- wBusy  out  1  high in ARMED, RUN, DECODE.
- wResValid  out  1  result available (DONE state).
- wResReady  in  1  readout accepts result.
- wCoarse  out  COARSE_BITS  coarse cycle count, start to stop.
- wFineStart  out  BITS_DECO  ones count of the latched start column.
- wFineStop  out  BITS_DECO  ones count of the latched stop column.
- wOverflow  out  1  no stop seen before the coarse counter saturated.

## Operation
- FSM states: IDLE, ARMED, RUN, DECODE, DONE. Reset state is IDLE.
- IDLE:
  - wArm=1 -> ARMED.
  - wStartHit and wStopHit are ignored.
- ARMED:
  - wStartHit=1 latches wStartCol, clears the coarse counter to 0 and moves to RUN.
  - A wStopHit in ARMED is ignored, including when it arrives in the same cycle as wStartHit.
- RUN:
  - The coarse counter increments by 1 each cycle.
  - wStopHit=1 latches wStopCol and moves to DECODE. wCoarse takes the count with that cycle's increment included, so a stop 1 cycle after start gives wCoarse=1.
  - Further wStartHit pulses are ignored.
  - Saturation: when the counter reaches 2^COARSE_BITS-1 with no stop, it holds at that value. The stop column is forced to all zeros, wOverflow is set and the FSM moves to DECODE. A stop in that same cycle takes priority, and wOverflow stays 0.
- DECODE:
  - Both columns are processed in parallel, one CHUNK slice per cycle, starting at bit 0.
  - Each cycle adds the popcount of the slice into a BITS_DECO accumulator. Popcount counts every 1 in the slice, so bubbles are tolerated.
  - After NUM_FF/CHUNK cycles the FSM moves to DONE. Accumulators are cleared on entry to DECODE.
- DONE:
  - wResValid=1, and all result outputs are held stable.
  - wResValid & wResReady -> IDLE; wResValid drops the next cycle.
  - wArm in DONE is ignored.
- wAbort has priority over every other input. It moves any state to IDLE and clears wResValid, wOverflow, the accumulators and the counter.
- Arithmetic: fine bins are unsigned, range 0..NUM_FF, and cannot overflow given the BITS_DECO rule. Coarse arithmetic is unsigned and saturating.

## Timing
- Reset values:
  - State IDLE.
  - wBusy=0, wResValid=0, wOverflow=0.
  - wCoarse=0, wFineStart=0, wFineStop=0.
- Asynchronous reset mid-operation discards everything. The first cycle after release is IDLE.
- Result outputs change only on entry to DONE and are stable while wResValid=1.
- wBusy is registered from the state: high the cycle after the ARMED entry edge, low the cycle after the DONE entry edge.
- Latency from the stop-sampling edge to wResValid=1 is NUM_FF/CHUNK + 1 cycles: NUM_FF/CHUNK decode cycles plus one DONE-entry edge.
- wResReady is sampled only when wResValid=1. Back-to-back measurements need one IDLE cycle to accept wArm.

## Test plan
Parameters for all scenarios: NUM_FF=16, CHUNK=4, BITS_DECO=5, COARSE_BITS=4.
- Basic measurement. Stimulus: wArm, then wStartHit with wStartCol=16'h003F; 5 cycles later wStopHit with wStopCol=16'h07FF; wResReady held high. Required response: wCoarse=5, wFineStart=6, wFineStop=11, wOverflow=0, wResValid exactly 5 cycles after the stop edge for one cycle.
- Overflow. Stimulus: start with wStartCol=16'hFFFF, no stop. Required response: after 15 RUN cycles wCoarse=15, wFineStop=0, wFineStart=16, wOverflow=1.
- Hit ordering. Stimulus: wStopHit in IDLE and ARMED; wStartHit and wStopHit in the same ARMED cycle; a second wStartHit in RUN. Required response: the spurious stops are ignored, the first start is the one latched, and the second start does not reset wCoarse.
- Backpressure. Stimulus: wResReady low for 10 cycles in DONE, with wArm pulsed during that time. Required response: outputs stable, wResValid held, state stays DONE; IDLE is reached one cycle after wResReady rises.
- Abort and reset. Stimulus: wAbort during DECODE; asynchronous wRstN low during RUN. Required response: IDLE next cycle with no wResValid; all outputs at their reset values immediately on wRstN low.
- Bubble tolerance. Stimulus: wStopCol=16'h0B7F. Required response: wFineStop=10.

Source files
------------

// File: rtl/tdc_measure_ctrl_if.sv
// Control, capture-column and result-handshake bundle for one TDC measurement channel.
interface tdc_measure_ctrl_if #(
  parameter int NUM_FF      = 64,
  parameter int BITS_DECO   = 8,
  parameter int COARSE_BITS = 16
);
  logic                   wArm;
  logic                   wAbort;
  logic                   wStartHit;
  logic                   wStopHit;
  logic [NUM_FF-1:0]      wStartCol;
  logic [NUM_FF-1:0]      wStopCol;
  logic                   wBusy;
  logic                   wResValid;
  logic                   wResReady;
  logic [COARSE_BITS-1:0] wCoarse;
  logic [BITS_DECO-1:0]   wFineStart;
  logic [BITS_DECO-1:0]   wFineStop;
  logic                   wOverflow;

  // Sequencer/readout side: drives requests, hits and columns, consumes results.
  modport master (
    output wArm, wAbort, wStartHit, wStopHit, wStartCol, wStopCol, wResReady,
    input  wBusy, wResValid, wCoarse, wFineStart, wFineStop, wOverflow
  );

  // Measurement controller side.
  modport slave (
    input  wArm, wAbort, wStartHit, wStopHit, wStartCol, wStopCol, wResReady,
    output wBusy, wResValid, wCoarse, wFineStart, wFineStop, wOverflow
  );
endinterface

// File: rtl/tdc_measure_ctrl.sv
// Measurement sequencer for one TDC channel: arms, latches the start/stop
// thermometer columns, counts coarse cycles between them, ones-counts both
// columns one CHUNK slice per cycle and hands the result to the readout.
module tdc_measure_ctrl #(
  parameter int NUM_FF      = 64,
  parameter int CHUNK       = 8,
  parameter int BITS_DECO   = 8,
  parameter int COARSE_BITS = 16
) (
  input logic              wClk,
  input logic              wRstN,
  tdc_measure_ctrl_if.slave tdc
);

  localparam int NSL = NUM_FF / CHUNK;
  localparam int IW  = $clog2(NSL + 1);
  localparam logic [IW-1:0]          LAST = IW'(NSL);
  localparam logic [COARSE_BITS-1:0] CMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_RUN, S_DECODE, S_DONE} state_t;

  state_t                 state;
  logic [COARSE_BITS-1:0] cnt;
  logic [COARSE_BITS-1:0] cnt_inc;
  logic [IW-1:0]          idx;
  logic [NUM_FF-1:0]      col_start;
  logic [NUM_FF-1:0]      col_stop;
  logic [BITS_DECO-1:0]   acc_start;
  logic [BITS_DECO-1:0]   acc_stop;
  logic                   ovf_flag;
  logic                   busy_r;
  logic                   valid_r;
  logic [COARSE_BITS-1:0] coarse_r;
  logic [BITS_DECO-1:0]   fine_start_r;
  logic [BITS_DECO-1:0]   fine_stop_r;
  logic                   ovf_r;

  // Ones count of one slice; every set bit counts, so bubbles are harmless.
  function automatic logic [BITS_DECO-1:0] popcnt(input logic [CHUNK-1:0] s);
    logic [BITS_DECO-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + BITS_DECO'(s[i]);
    return n;
  endfunction

  // Coarse count never wraps; it sticks at all-ones.
  function automatic logic [COARSE_BITS-1:0] sat_inc(input logic [COARSE_BITS-1:0] c);
    return (c == CMAX) ? c : c + 1'b1;
  endfunction

  // Next coarse value including the current RUN cycle.
  always_comb cnt_inc = sat_inc(cnt);

  // Sequencer FSM with registered status and result outputs.
  always_ff @(posedge wClk or negedge wRstN) begin
    if (!wRstN) begin
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      acc_start    <= '0;
      acc_stop     <= '0;
      ovf_flag     <= 1'b0;
      busy_r       <= 1'b0;
      valid_r      <= 1'b0;
      coarse_r     <= '0;
      fine_start_r <= '0;
      fine_stop_r  <= '0;
      ovf_r        <= 1'b0;
    end else if (tdc.wAbort) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      acc_start <= '0;
      acc_stop  <= '0;
      ovf_flag  <= 1'b0;
      busy_r    <= 1'b0;
      valid_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tdc.wArm) begin
            state  <= S_ARMED;
            busy_r <= 1'b1;
          end
        end
        S_ARMED: begin
          if (tdc.wStartHit) begin
            cnt      <= '0;
            ovf_flag <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt_inc;
          if (tdc.wStopHit || cnt_inc == CMAX) begin
            ovf_flag  <= !tdc.wStopHit;
            acc_start <= '0;
            acc_stop  <= '0;
            idx       <= '0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (idx == LAST) begin
            coarse_r     <= cnt;
            fine_start_r <= acc_start;
            fine_stop_r  <= acc_stop;
            ovf_r        <= ovf_flag;
            valid_r      <= 1'b1;
            busy_r       <= 1'b0;
            state        <= S_DONE;
          end else begin
            acc_start <= acc_start + popcnt(col_start[CHUNK-1:0]);
            acc_stop  <= acc_stop + popcnt(col_stop[CHUNK-1:0]);
            idx       <= idx + 1'b1;
          end
        end
        S_DONE: begin
          if (tdc.wResReady) begin
            valid_r <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Column snapshots: latched on the hit edges, then shifted down one slice per decode cycle.
  always_ff @(posedge wClk) begin
    if (!tdc.wAbort) begin
      case (state)
        S_ARMED: begin
          if (tdc.wStartHit) col_start <= tdc.wStartCol;
        end
        S_RUN: begin
          if (tdc.wStopHit)         col_stop <= tdc.wStopCol;
          else if (cnt_inc == CMAX) col_stop <= '0;
        end
        S_DECODE: begin
          if (idx != LAST) begin
            col_start <= col_start >> CHUNK;
            col_stop  <= col_stop >> CHUNK;
          end
        end
        default: ;
      endcase
    end
  end

  assign tdc.wBusy      = busy_r;
  assign tdc.wResValid  = valid_r;
  assign tdc.wCoarse    = coarse_r;
  assign tdc.wFineStart = fine_start_r;
  assign tdc.wFineStop  = fine_stop_r;
  assign tdc.wOverflow  = ovf_r;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Bench for tdc_measure_ctrl: directed measurements with hand-computed results
// pushed to a scoreboard, a monitor popping on each accepted result.
module tb_tdc_measure_ctrl;

  localparam int NUM_FF      = 16;
  localparam int CHUNK       = 4;
  localparam int BITS_DECO   = 5;
  localparam int COARSE_BITS = 4;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    int coarse;
    int fs;
    int fp;
    int ovf;
  } exp_t;

  exp_t sbq[$];

  tdc_measure_ctrl_if #(.NUM_FF(NUM_FF), .BITS_DECO(BITS_DECO), .COARSE_BITS(COARSE_BITS)) bus ();

  tdc_measure_ctrl #(
    .NUM_FF(NUM_FF), .CHUNK(CHUNK), .BITS_DECO(BITS_DECO), .COARSE_BITS(COARSE_BITS)
  ) dut (
    .wClk (clk),
    .wRstN(rst_n),
    .tdc  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input int fs, input int fp, input int o);
    exp_t e;
    e.coarse = c; e.fs = fs; e.fp = fp; e.ovf = o;
    sbq.push_back(e);
  endtask

  // Count edges until wResValid rises; an expired bound shows up as a wrong latency.
  task automatic wait_valid(input string nm, input int exp_lat, input int limit);
    int n;
    n = 0;
    while (!bus.wResValid && n < limit) begin
      tick();
      n++;
    end
    check(nm, n, exp_lat);
  endtask

  // Monitor: compare each accepted result against the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.wResValid && bus.wResReady) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("sb_coarse",     int'(bus.wCoarse),    e.coarse);
        check("sb_fine_start", int'(bus.wFineStart), e.fs);
        check("sb_fine_stop",  int'(bus.wFineStop),  e.fp);
        check("sb_overflow",   int'(bus.wOverflow),  e.ovf);
      end
    end
  end

  task automatic arm();
    bus.wArm = 1'b1;
    tick();
    bus.wArm = 1'b0;
  endtask

  task automatic start(input logic [NUM_FF-1:0] col);
    bus.wStartHit = 1'b1;
    bus.wStartCol = col;
    tick();
    bus.wStartHit = 1'b0;
  endtask

  task automatic stop(input logic [NUM_FF-1:0] col);
    bus.wStopHit = 1'b1;
    bus.wStopCol = col;
    tick();
    bus.wStopHit = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int seen;
    rst_n         = 1'b0;
    bus.wArm      = 1'b0;
    bus.wAbort    = 1'b0;
    bus.wStartHit = 1'b0;
    bus.wStopHit  = 1'b0;
    bus.wStartCol = '0;
    bus.wStopCol  = '0;
    bus.wResReady = 1'b1;

    #2;
    check("rst_busy",   int'(bus.wBusy),      0);
    check("rst_valid",  int'(bus.wResValid),  0);
    check("rst_ovf",    int'(bus.wOverflow),  0);
    check("rst_coarse", int'(bus.wCoarse),    0);
    check("rst_fs",     int'(bus.wFineStart), 0);
    check("rst_fp",     int'(bus.wFineStop),  0);
    #10 rst_n = 1'b1;
    tick();

    // Basic measurement: stop 5 cycles after start.
    arm();
    check("basic_busy_armed", int'(bus.wBusy), 1);
    push(5, 6, 11, 0);
    start(16'h003F);
    idle(4);
    stop(16'h07FF);
    wait_valid("basic_latency", 5, 30);
    check("basic_busy_done", int'(bus.wBusy), 0);
    tick();
    check("basic_valid_one_cycle", int'(bus.wResValid), 0);

    // Hit ordering: spurious stops, simultaneous start/stop, repeated start.
    bus.wStopHit = 1'b1;
    bus.wStopCol = 16'hFFFF;
    tick();
    bus.wArm = 1'b1;
    tick();
    bus.wArm = 1'b0;
    tick();
    bus.wStopHit  = 1'b0;
    check("order_busy_armed", int'(bus.wBusy), 1);
    push(4, 4, 2, 0);
    bus.wStartHit = 1'b1;
    bus.wStopHit  = 1'b1;
    bus.wStartCol = 16'h000F;
    bus.wStopCol  = 16'hFFFF;
    tick();
    bus.wStartHit = 1'b0;
    bus.wStopHit  = 1'b0;
    tick();
    start(16'hFFFF);
    tick();
    stop(16'h0003);
    wait_valid("order_latency", 5, 30);
    tick();

    // Overflow: no stop, coarse saturates at 15.
    arm();
    push(15, 16, 0, 1);
    start(16'hFFFF);
    wait_valid("ovf_latency", 20, 60);
    tick();
    check("ovf_held_in_idle", int'(bus.wOverflow), 1);

    // Abort during DECODE.
    arm();
    start(16'h0001);
    stop(16'h0001);
    idle(2);
    bus.wAbort = 1'b1;
    tick();
    bus.wAbort = 1'b0;
    check("abort_busy",  int'(bus.wBusy),     0);
    check("abort_valid", int'(bus.wResValid), 0);
    check("abort_ovf",   int'(bus.wOverflow), 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.wResValid) seen = 1;
    end
    check("abort_no_valid", seen, 0);

    // Backpressure: ready low for 10 DONE cycles with a stray arm.
    bus.wResReady = 1'b0;
    arm();
    push(2, 1, 8, 0);
    start(16'h0001);
    tick();
    stop(16'h0F0F);
    wait_valid("bp_latency", 5, 30);
    for (int i = 0; i < 10; i++) begin
      bus.wArm = (i == 3);
      tick();
      check("bp_valid_held", int'(bus.wResValid),  1);
      check("bp_coarse",     int'(bus.wCoarse),    2);
      check("bp_fs",         int'(bus.wFineStart), 1);
      check("bp_fp",         int'(bus.wFineStop),  8);
    end
    bus.wArm = 1'b0;
    check("bp_busy_done", int'(bus.wBusy), 0);
    bus.wResReady = 1'b1;
    tick();
    check("bp_valid_drop", int'(bus.wResValid), 0);
    check("bp_not_rearmed", int'(bus.wBusy), 0);
    arm();
    check("bp_idle_accepts_arm", int'(bus.wBusy), 1);
    bus.wAbort = 1'b1;
    tick();
    bus.wAbort = 1'b0;

    // Asynchronous reset during RUN.
    arm();
    start(16'h00FF);
    idle(2);
    #3 rst_n = 1'b0;
    #1;
    check("arst_busy",   int'(bus.wBusy),      0);
    check("arst_valid",  int'(bus.wResValid),  0);
    check("arst_ovf",    int'(bus.wOverflow),  0);
    check("arst_coarse", int'(bus.wCoarse),    0);
    check("arst_fs",     int'(bus.wFineStart), 0);
    check("arst_fp",     int'(bus.wFineStop),  0);
    #2 rst_n = 1'b1;
    tick();
    check("arst_idle_busy", int'(bus.wBusy), 0);

    // Bubble in the stop column.
    arm();
    push(3, 8, 10, 0);
    start(16'h00FF);
    idle(2);
    stop(16'h0B7F);
    wait_valid("bubble_latency", 5, 30);
    idle(3);

    check("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
